// File: rtl/ann_pkg.sv
// Shared constants and FSM encoding for the layer neuron datapath.
package ann_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned FRAC  = 8;
    localparam int unsigned N_IN  = 28;
    localparam int unsigned AW    = 5;
    localparam int unsigned ACC_W = 40;

    localparam logic signed [DW-1:0] Y_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] Y_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2,
        S_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/neuron_sat_relu.sv
// Output stage: drop fraction bits, add bias, saturate to DW, optional ReLU.
module neuron_sat_relu #(
    parameter int unsigned ACC_W = ann_pkg::ACC_W,
    parameter int unsigned FRAC  = ann_pkg::FRAC,
    parameter bit          RELU  = 1'b1
) (
    input  logic [ACC_W-1:0]         i_acc,
    input  logic [ann_pkg::DW-1:0]   i_bias,
    output logic [ann_pkg::DW-1:0]   o_y_c
);
    import ann_pkg::*;

    logic signed [ACC_W-1:0] w_shift;
    logic signed [ACC_W-1:0] w_bias;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_max;
    logic signed [ACC_W-1:0] w_min;
    logic        [DW-1:0]    w_sat;

    // Arithmetic shift floors toward -inf, matching Q7.8 truncation.
    assign w_shift = $signed(i_acc) >>> FRAC;
    assign w_bias  = {{(ACC_W-DW){i_bias[DW-1]}}, i_bias};
    assign w_sum   = w_shift + w_bias;
    assign w_max   = {{(ACC_W-DW){1'b0}}, Y_MAX};
    assign w_min   = {{(ACC_W-DW){1'b1}}, Y_MIN};

    always_comb begin
        w_sat = w_sum[DW-1:0];
        if (w_sum > w_max) begin
            w_sat = Y_MAX;
        end else if (w_sum < w_min) begin
            w_sat = Y_MIN;
        end
        o_y_c = w_sat;
        if (RELU && w_sat[DW-1]) begin
            o_y_c = '0;
        end
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential multiply-accumulate neuron: sweeps weight/activation memories,
// then applies bias, saturation and optional ReLU to produce one output.
module neuron_mac_seq #(
    parameter int unsigned N_IN  = ann_pkg::N_IN,
    parameter int unsigned DW    = ann_pkg::DW,
    parameter int unsigned AW    = ann_pkg::AW,
    parameter int unsigned FRAC  = ann_pkg::FRAC,
    parameter int unsigned ACC_W = ann_pkg::ACC_W,
    parameter bit          RELU  = 1'b1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    output logic [AW-1:0] ADDR,
    output logic          EN,
    input  logic [DW-1:0] W_DO,
    input  logic [DW-1:0] X_DO,
    input  logic [DW-1:0] BIAS,
    output logic          BUSY,
    output logic          DONE,
    output logic [DW-1:0] Y
);
    import ann_pkg::*;

    if (ACC_W < 2*DW + $clog2(N_IN)) begin : g_chk_acc
        $error("neuron_mac_seq: ACC_W too narrow, accumulator may wrap");
    end
    if (N_IN < 2 || N_IN > (2**AW)) begin : g_chk_addr
        $error("neuron_mac_seq: N_IN must be >= 2 and addressable with AW bits");
    end
    if (DW != ann_pkg::DW) begin : g_chk_dw
        $error("neuron_mac_seq: DW must match ann_pkg::DW");
    end

    localparam logic [AW-1:0] PRE_LAST = AW'(N_IN - 2);

    state_e              r_state, w_state_nxt;
    logic [AW-1:0]       r_addr,  w_addr_nxt;
    logic                r_en,    w_en_nxt;
    logic                r_busy,  w_busy_nxt;
    logic                r_done,  w_done_nxt;
    logic [DW-1:0]       r_y,     w_y_nxt;
    logic [ACC_W-1:0]    r_acc,   w_acc_nxt;

    logic signed [2*DW-1:0] w_prod;
    logic [ACC_W-1:0]       w_prod_ext;
    logic [DW-1:0]          w_y_c;

    assign w_prod     = $signed(W_DO) * $signed(X_DO);
    assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};

    neuron_sat_relu #(
        .ACC_W (ACC_W),
        .FRAC  (FRAC),
        .RELU  (RELU)
    ) u_sat (
        .i_acc  (r_acc),
        .i_bias (BIAS),
        .o_y_c  (w_y_c)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_y     <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_en    <= w_en_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_y     <= w_y_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    // Memory data lags ADDR by one cycle, so each edge consumes the previous address.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_en_nxt    = r_en;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_y_nxt     = r_y;
        w_acc_nxt   = r_acc;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = S_RUN;
                    w_addr_nxt  = '0;
                    w_en_nxt    = 1'b1;
                    w_acc_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                w_acc_nxt  = r_acc + w_prod_ext;
                w_addr_nxt = r_addr + AW'(1);
                if (r_addr == PRE_LAST) begin
                    w_state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                w_acc_nxt   = r_acc + w_prod_ext;
                w_en_nxt    = 1'b0;
                w_addr_nxt  = '0;
                w_state_nxt = S_FIN;
            end
            S_FIN: begin
                w_y_nxt     = w_y_c;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ADDR = r_addr;
    assign EN   = r_en;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign Y    = r_y;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: ReLU and linear instances share falling-edge memory models.
module tb_neuron_mac_seq;

    localparam int unsigned N = 28;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] bias;
    logic [15:0] w_do;
    logic [15:0] x_do;
    logic [4:0]  addr1, addr0;
    logic        en1, en0, busy1, busy0, done1, done0;
    logic [15:0] y1, y0;

    logic [15:0] wmem [N];
    logic [15:0] xmem [N];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (en1) begin
            w_do <= wmem[addr1];
            x_do <= xmem[addr1];
        end
    end

    neuron_mac_seq #(.RELU(1'b1)) dut_relu (
        .CLK(clk), .RST_N(rst_n), .START(start), .ADDR(addr1), .EN(en1),
        .W_DO(w_do), .X_DO(x_do), .BIAS(bias), .BUSY(busy1), .DONE(done1), .Y(y1)
    );

    neuron_mac_seq #(.RELU(1'b0)) dut_lin (
        .CLK(clk), .RST_N(rst_n), .START(start), .ADDR(addr0), .EN(en0),
        .W_DO(w_do), .X_DO(x_do), .BIAS(bias), .BUSY(busy0), .DONE(done0), .Y(y0)
    );

    typedef struct {
        string       name;
        logic [15:0] w_base;
        logic [15:0] w_step;
        logic [15:0] x_val;
        logic        single;
        logic [15:0] b;
        logic [15:0] exp_relu;
        logic [15:0] exp_lin;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < N; i++) begin
            if (v.single) begin
                wmem[i] = (i == 5) ? v.w_base : 16'h0000;
                xmem[i] = (i == 5) ? v.x_val  : 16'h0000;
            end else begin
                wmem[i] = v.w_base + 16'(i) * v.w_step;
                xmem[i] = v.x_val;
            end
        end
        bias = v.b;
    endtask

    // Pulses START, then follows the run cycle by cycle (k = cycles after the START edge).
    task automatic run_op(output int lat, output int en_cnt, output int addr_bad,
                          output int busy_bad, output logic [15:0] y_r,
                          output logic [15:0] y_l, output int done_after);
        lat = -1; en_cnt = 0; addr_bad = 0; busy_bad = 0;
        y_r = '0; y_l = '0; done_after = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (en1) begin
                if (addr1 != 5'(en_cnt)) addr_bad++;
                en_cnt++;
            end
            if (done1) begin
                lat = k; y_r = y1; y_l = y0;
                if (busy1 || !done0) busy_bad++;
                break;
            end
            if (!busy1) busy_bad++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        done_after = int'(done1 | done0);
    endtask

    int lat, en_cnt, addr_bad, busy_bad, done_after;
    logic [15:0] yr, yl;

    initial begin
        vecs[0]  = '{"ones",      16'h0100, 16'h0000, 16'h0100, 1'b0, 16'h0000, 16'h1C00, 16'h1C00};
        vecs[1]  = '{"neg",       16'hFF00, 16'h0000, 16'h0100, 1'b0, 16'h0200, 16'h0000, 16'hE600};
        vecs[2]  = '{"pos_sat",   16'h7FFF, 16'h0000, 16'h7FFF, 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[3]  = '{"neg_sat",   16'h8000, 16'h0000, 16'h7FFF, 1'b0, 16'h0000, 16'h0000, 16'h8000};
        vecs[4]  = '{"ramp",      16'h0000, 16'h0010, 16'h0100, 1'b0, 16'h0000, 16'h17A0, 16'h17A0};
        vecs[5]  = '{"floor",     16'hFFFF, 16'h0000, 16'h0040, 1'b1, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[6]  = '{"small",     16'h0001, 16'h0000, 16'h0080, 1'b0, 16'hFFF0, 16'h0000, 16'hFFFE};
        vecs[7]  = '{"max_exact", 16'h0100, 16'h0000, 16'h0100, 1'b0, 16'h63FF, 16'h7FFF, 16'h7FFF};
        vecs[8]  = '{"max_over",  16'h0100, 16'h0000, 16'h0100, 1'b0, 16'h6400, 16'h7FFF, 16'h7FFF};
        vecs[9]  = '{"min_exact", 16'hFF00, 16'h0000, 16'h0100, 1'b0, 16'h9C00, 16'h0000, 16'h8000};
        vecs[10] = '{"min_over",  16'hFF00, 16'h0000, 16'h0100, 1'b0, 16'h9BFF, 16'h0000, 16'h8000};

        rst_n = 1'b0; start = 1'b0; bias = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {addr1, en1, busy1, done1, y1, addr0, en0, y0},
              {5'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 16'h0000});
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 11; v++) begin
            load(vecs[v]);
            run_op(lat, en_cnt, addr_bad, busy_bad, yr, yl, done_after);
            check({vecs[v].name, "_y_relu"}, 32'(yr), 32'(vecs[v].exp_relu));
            check({vecs[v].name, "_y_lin"},  32'(yl), 32'(vecs[v].exp_lin));
            check({vecs[v].name, "_latency"}, 32'(lat), 32'd29);
            check({vecs[v].name, "_en_cycles"}, 32'(en_cnt), 32'd28);
            check({vecs[v].name, "_addr_seq_errs"}, 32'(addr_bad), 32'd0);
            check({vecs[v].name, "_busy_errs"}, 32'(busy_bad), 32'd0);
            check({vecs[v].name, "_done_pulse"}, 32'(done_after), 32'd0);
            check({vecs[v].name, "_y_held"}, 32'({y1, y0}), 32'({vecs[v].exp_relu, vecs[v].exp_lin}));
        end

        // START ignored mid-run; START on the DONE cycle is accepted.
        begin
            int dones, first_k, second_k;
            logic [15:0] y_first, y_second;
            dones = 0; first_k = -1; second_k = -1; y_first = '0; y_second = '0;
            load(vecs[0]);
            start = 1'b1;
            @(posedge clk); #1;
            for (int k = 0; k < 100; k++) begin
                start = (k == 5 || k == 20) ? 1'b1 : 1'b0;
                if (done1) begin
                    dones++;
                    if (first_k < 0) begin
                        first_k = k; y_first = y1; start = 1'b1;
                    end else begin
                        second_k = k; y_second = y1;
                    end
                end
                @(posedge clk); #1;
            end
            start = 1'b0;
            check("repulse_done_count", 32'(dones), 32'd2);
            check("repulse_first_lat", 32'(first_k), 32'd29);
            check("b2b_spacing", 32'(second_k - first_k), 32'd30);
            check("b2b_y", 32'({y_first, y_second}), 32'h1C001C00);
        end

        // Reset mid-run aborts immediately with no DONE afterwards.
        begin
            int late_done;
            late_done = 0;
            load(vecs[4]);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (12) @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check("abort_outputs", {addr1, en1, busy1, done1, y1, y0},
                  {5'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000});
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            for (int k = 0; k < 40; k++) begin
                if (done1 || done0 || busy1) late_done++;
                @(posedge clk); #1;
            end
            check("abort_no_done", 32'(late_done), 32'd0);
            run_op(lat, en_cnt, addr_bad, busy_bad, yr, yl, done_after);
            check("after_abort_y", 32'({yr, yl}), 32'h17A017A0);
            check("after_abort_latency", 32'(lat), 32'd29);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
